// File: rtl/ascii_word_receiver.sv
// Drains the UART RX FIFO and rebuilds 16-bit words from 4-character ASCII
// frames ('0'..'?' carry one nibble each, MS nibble first).
module ascii_word_receiver #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  rx_pop_data,
  output logic        rx_pop,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_WAIT, S_CHECK} state_t;

  state_t        state;
  logic [7:0]    byte_reg;
  logic [15:0]   shift_reg;
  logic [2:0]    cnt;
  logic [TW-1:0] tmo;

  logic          is_digit;
  logic          is_eol;
  logic [15:0]   shift_next;
  logic [2:0]    cnt_inc;

  assign is_digit   = (byte_reg[7:4] == 4'h3);
  assign is_eol     = (byte_reg == 8'h0D) || (byte_reg == 8'h0A);
  assign shift_next = {shift_reg[11:0], byte_reg[3:0]};
  assign cnt_inc    = cnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      byte_reg  <= 8'h00;
      shift_reg <= 16'h0000;
      cnt       <= 3'd0;
      tmo       <= '0;
      rx_pop    <= 1'b0;
      o_data    <= 16'h0000;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      rx_pop    <= 1'b0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        S_WAIT: begin
          // The timeout clears cnt at the same edge a new byte is latched,
          // so that byte is classified as the first nibble of a fresh frame.
          if (cnt != 3'd0) begin
            if (tmo == TMO_LAST) begin
              cnt       <= 3'd0;
              tmo       <= '0;
              o_timeout <= 1'b1;
              o_busy    <= 1'b0;
            end else begin
              tmo <= tmo + TW'(1);
            end
          end else begin
            tmo <= '0;
          end
          if (!rx_empty) begin
            byte_reg <= rx_pop_data;
            rx_pop   <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          tmo   <= '0;
          state <= S_WAIT;
          if (is_digit) begin
            shift_reg <= shift_next;
            if (cnt_inc == 3'd4) begin
              o_data  <= shift_next;
              o_valid <= 1'b1;
              cnt     <= 3'd0;
              o_busy  <= 1'b0;
            end else begin
              cnt    <= cnt_inc;
              o_busy <= 1'b1;
            end
          end else begin
            cnt    <= 3'd0;
            o_busy <= 1'b0;
            if (!is_eol) o_err <= 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_word_receiver.sv
// Directed bench for ascii_word_receiver: a small FWFT FIFO model feeds bytes,
// outputs are sampled on the falling edge.
module tb_ascii_word_receiver;

  logic        clk;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  rx_pop_data;
  logic        rx_pop;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_err;
  logic        o_timeout;
  logic        o_busy;

  ascii_word_receiver #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_empty   (rx_empty),
    .rx_pop_data(rx_pop_data),
    .rx_pop     (rx_pop),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_timeout  (o_timeout),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: written by the stimulus, popped on the clock edge.
  logic [7:0] mem [64];
  logic [6:0] wr_ptr = '0;
  logic [6:0] rd_ptr = '0;
  assign rx_empty    = (wr_ptr == rd_ptr);
  assign rx_pop_data = mem[rd_ptr[5:0]];

  always @(posedge clk) if (rx_pop) rd_ptr <= rd_ptr + 7'd1;

  int pop_cnt = 0, valid_cnt = 0, err_cnt = 0, tmo_cnt = 0, busy_cnt = 0, underflow_cnt = 0;
  always @(negedge clk) begin
    if (rx_pop) pop_cnt <= pop_cnt + 1;
    if (rx_pop && rx_empty) underflow_cnt <= underflow_cnt + 1;
    if (o_valid) valid_cnt <= valid_cnt + 1;
    if (o_err) err_cnt <= err_cnt + 1;
    if (o_timeout) tmo_cnt <= tmo_cnt + 1;
    if (o_busy) busy_cnt <= busy_cnt + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 7'd1;
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge of
  // the cycle where o_valid/o_err for this byte must be visible.
  task automatic send(input logic [7:0] b);
    push(b);
    @(negedge clk);
    chk($sformatf("rx_pop byte %02h", b), {31'd0, rx_pop}, 32'd1);
    @(negedge clk);
    $display("sent %02h: o_valid=%0b o_err=%0b o_data=%04h o_busy=%0b", b, o_valid, o_err, o_data, o_busy);
  endtask

  task automatic send_quiet(input logic [7:0] b, input logic [15:0] held);
    send(b);
    chk("o_valid idle", {31'd0, o_valid}, 32'd0);
    chk("o_data held", {16'd0, o_data}, {16'd0, held});
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_pop", {31'd0, rx_pop}, 32'd0);
    chk("reset o_data", {16'd0, o_data}, 32'd0);
    chk("reset o_valid", {31'd0, o_valid}, 32'd0);
    chk("reset o_err", {31'd0, o_err}, 32'd0);
    chk("reset o_timeout", {31'd0, o_timeout}, 32'd0);
    chk("reset o_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;

    // Empty FIFO for 100 cycles: nothing may happen
    repeat (100) @(negedge clk);
    #1;
    chk("idle pops", pop_cnt, 0);
    chk("idle valids", valid_cnt, 0);
    chk("idle errs", err_cnt, 0);
    chk("idle timeouts", tmo_cnt, 0);
    chk("idle busy", busy_cnt, 0);

    // Preloaded frame "12:?" -> 0x12AF; pops every other cycle
    @(negedge clk);
    push(8'h31); push(8'h32); push(8'h3A); push(8'h3F);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("preload rx_pop c%0d", i), {31'd0, rx_pop}, {31'd0, (i % 2 == 1) && (i <= 7)});
      chk($sformatf("preload o_valid c%0d", i), {31'd0, o_valid}, {31'd0, i == 8});
    end
    $display("preload frame: o_data=%04h", o_data);
    chk("preload o_data", {16'd0, o_data}, 32'h12AF);
    chk("preload busy mid", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("preload valid width", {31'd0, o_valid}, 32'd0);
    chk("preload o_busy after", {31'd0, o_busy}, 32'd0);

    // Illegal 'A' mid-frame, then a clean frame
    send_quiet(8'h31, 16'h12AF);
    send_quiet(8'h32, 16'h12AF);
    chk("busy before A", {31'd0, o_busy}, 32'd1);
    send(8'h41);
    chk("o_err on A", {31'd0, o_err}, 32'd1);
    chk("o_valid on A", {31'd0, o_valid}, 32'd0);
    chk("o_data held on A", {16'd0, o_data}, 32'h12AF);
    chk("busy after A", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    chk("o_err width", {31'd0, o_err}, 32'd0);
    send_quiet(8'h33, 16'h12AF);
    send_quiet(8'h34, 16'h12AF);
    send_quiet(8'h35, 16'h12AF);
    send(8'h36);
    chk("resync o_valid", {31'd0, o_valid}, 32'd1);
    chk("resync o_data", {16'd0, o_data}, 32'h3456);

    // Timeout: CHECK of 0x38 is cycle C; WAIT cycles C+1..C+16 count, and the
    // registered pulse is visible in cycle C+17. send() returns in C+1.
    send_quiet(8'h37, 16'h3456);
    send_quiet(8'h38, 16'h3456);
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      chk($sformatf("tmo pulse C+%0d", i), {31'd0, o_timeout}, {31'd0, i == 17});
      chk($sformatf("tmo busy C+%0d", i), {31'd0, o_busy}, {31'd0, i < 17});
    end
    $display("timeout pulse observed, o_busy=%0b", o_busy);
    repeat (3) @(negedge clk);
    chk("tmo width", {31'd0, o_timeout}, 32'd0);
    send_quiet(8'h30, 16'h3456);
    send_quiet(8'h30, 16'h3456);
    send_quiet(8'h30, 16'h3456);
    send(8'h31);
    chk("post-tmo o_valid", {31'd0, o_valid}, 32'd1);
    chk("post-tmo o_data", {16'd0, o_data}, 32'h0001);

    // CR/LF resynchronise without an error
    send_quiet(8'h39, 16'h0001);
    send(8'h0D);
    chk("CR no err", {31'd0, o_err}, 32'd0);
    chk("CR busy", {31'd0, o_busy}, 32'd0);
    send_quiet(8'h31, 16'h0001);
    send_quiet(8'h32, 16'h0001);
    send_quiet(8'h33, 16'h0001);
    send(8'h34);
    chk("CRLF o_valid", {31'd0, o_valid}, 32'd1);
    chk("CRLF o_data", {16'd0, o_data}, 32'h1234);
    send(8'h0A);
    chk("LF no err", {31'd0, o_err}, 32'd0);
    chk("LF no valid", {31'd0, o_valid}, 32'd0);

    // Reset mid-frame takes effect asynchronously and drops the partial frame
    send_quiet(8'h3F, 16'h1234);
    send_quiet(8'h3F, 16'h1234);
    send_quiet(8'h3F, 16'h1234);
    chk("busy before rst", {31'd0, o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst o_data", {16'd0, o_data}, 32'd0);
    chk("async rst o_busy", {31'd0, o_busy}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst o_data", {16'd0, o_data}, 32'd0);
      chk("rst pulses", {29'd0, o_valid, o_err, o_timeout}, 32'd0);
      chk("rst rx_pop", {31'd0, rx_pop}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst pulses", {29'd0, o_valid, o_err, o_timeout}, 32'd0);
    send_quiet(8'h30, 16'h0000);
    send_quiet(8'h30, 16'h0000);
    send_quiet(8'h30, 16'h0000);
    send(8'h30);
    chk("post-rst o_valid", {31'd0, o_valid}, 32'd1);
    chk("post-rst o_data", {16'd0, o_data}, 32'h0000);

    // Totals over the whole run
    repeat (4) @(negedge clk);
    #1;
    chk("total pops", pop_cnt, 31);
    chk("total valids", valid_cnt, 5);
    chk("total errs", err_cnt, 1);
    chk("total timeouts", tmo_cnt, 1);
    chk("underflows", underflow_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_word_receiver.md
# ascii_word_receiver

Receive-side counterpart of the board's ASCII word sender. It drains bytes from the UART controller's RX FIFO and reassembles 16-bit words from 4-character ASCII frames. Each character encodes one nibble as 0x30 + nibble (0x30..0x3F), most-significant nibble first. It sits between the UART controller's RX FIFO pop port and user logic (FND display, register load), and provides framing resync, error flagging and an inter-byte timeout.

## Interface
- TIMEOUT_CYCLES, default 1_000_000: idle clk cycles allowed between bytes of a partial frame (10 ms at 100 MHz); must be ≥ 4.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-high.
- rx_empty  in  1  RX FIFO empty flag; when 0, rx_pop_data holds the head byte (first-word-fall-through).
- rx_pop_data  in  8  RX FIFO head byte.
- rx_pop  out  1  one-cycle pop strobe to the RX FIFO; registered.
- o_data  out  16  last completed word; held until the next completed frame.
- o_valid  out  1  one-cycle pulse; o_data updated in the same cycle.
- o_err  out  1  one-cycle pulse; an illegal byte was received inside a frame or at frame start.
- o_timeout  out  1  one-cycle pulse; a partial frame was discarded by the timeout.
- o_busy  out  1  high while a partial frame (1–3 nibbles) is held.

## Operation
- FSM states:
  - WAIT (reset state): if rx_empty=0, latch rx_pop_data into byte_reg and go to CHECK. Otherwise stay.
  - CHECK: rx_pop=1 for exactly this cycle. Classify byte_reg, then return to WAIT.
- Classification in CHECK:
  - 0x30..0x3F: nibble = byte_reg[3:0]; shift_next = {shift[11:0], nibble}; cnt += 1.
    - If cnt becomes 4: o_data ← shift_next, o_valid pulse, cnt ← 0.
  - 0x0D or 0x0A (CR/LF): discard the partial frame (cnt ← 0). No error pulse.
  - Any other byte: discard the partial frame, cnt ← 0, o_err pulse.
- No terminator is required; a frame is exactly 4 legal characters.
- Timeout:
  - Counter clears on every CHECK and whenever cnt=0.
  - It increments each WAIT cycle while cnt ∈ {1,2,3}.
  - On reaching TIMEOUT_CYCLES: cnt ← 0 and o_timeout pulses.
  - If the timeout and a byte arrival occur in the same WAIT cycle, the timeout wins. The byte is still latched and processed as the first nibble of a new frame.
- o_busy = (cnt ≠ 0).
- Counter width = $clog2(TIMEOUT_CYCLES+1). The nibble counter is 3 bits and never exceeds 4.
- The block never pops while rx_empty=1. Since it pops only in CHECK after seeing rx_empty=0 in WAIT, FIFO underflow is impossible.

## Timing
- Reset values: rx_pop=0, o_data=16'h0000, o_valid=0, o_err=0, o_timeout=0, o_busy=0; FSM=WAIT, cnt=0, shift=0, timeout counter=0.
- Byte throughput: at most one byte per 2 cycles (WAIT then CHECK).
- Latency: if WAIT sees rx_empty=0 in cycle N, then rx_pop=1 in cycle N+1, and o_valid/o_err (and the o_data update) are high in cycle N+2.
- All outputs are registered; pulses are exactly 1 cycle wide.
- rx_empty is re-sampled in the WAIT cycle after CHECK, which allows for the FIFO's 1-cycle flag update.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). The partial frame is lost, and no pulse is emitted when reset is released.
- When o_valid and o_err would coincide: impossible by construction, since only one byte is classified per CHECK.

## Test plan
- FIFO preloaded with 0x31 0x32 0x3A 0x3F → rx_pop pulses 4 times, 2 cycles apart; a single o_valid with o_data=16'h12AF; o_busy low afterwards.
- 0x31 0x32 0x41 then 0x33 0x34 0x35 0x36 → o_err pulse 2 cycles after the 'A' is seen; next o_valid has o_data=16'h3456; o_data stays at its prior value in between.
- With TIMEOUT_CYCLES=16: send 0x37 0x38, leave the FIFO empty for 20 cycles, then send 0x30 0x30 0x30 0x31.
  - Required: o_timeout pulses exactly 16 WAIT cycles after the 0x38 CHECK, then o_valid with 16'h0001.
- Sequence 0x39 0x0D 0x31 0x32 0x33 0x34 0x0A → no o_err, one o_valid with 16'h1234.
- Assert rst for 2 cycles after 3 nibbles of 0x3F, then send 0x30 0x30 0x30 0x30 → all outputs at reset values during rst; next o_valid gives 16'h0000 (not 16'hFFF0).
- Hold rx_empty=1 for 100 cycles after reset → rx_pop, o_valid, o_err and o_timeout never assert; o_busy stays 0.
